dmem_responder: RTL and testbench

Single-port data-memory responder on the data-side memory interface, driven by the pipeline's memory-access stage. It accepts one load or store request at a time and holds the initiator with `dmem_stall_o` for a fixed number of wait states. It performs the access on an internal byte-enabled word array, then releases the pipeline with a one-cycle completion pulse carrying load data or a misalignment flag.

---
 rtl/dmem_pkg.sv | 33 +++
 rtl/dmem_sram.sv | 33 +++
 rtl/dmem_responder.sv | 149 ++++++++++++++
 tb/tb_dmem_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the data-memory responder.
package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_e;

  // Little-endian lane mask for an aligned access; reserved size selects no lanes.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_B:  byte_en = 4'b0001 << addr_lo;
      SIZE_H:  byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_B:  is_misaligned = 1'b0;
      SIZE_H:  is_misaligned = addr_lo[0];
      SIZE_W:  is_misaligned = |addr_lo;
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port word array with per-byte write enables and a read-first registered read.
module dmem_sram #(
  parameter int DW    = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            en,
  input  logic            we,
  input  logic [DW/8-1:0] be,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  // The read samples the word before any write landing on the same edge.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata_q <= mem[addr];
      for (int i = 0; i < DW / 8; i++) begin
        if (we && be[i]) begin
          mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-side memory responder: accepts one load/store, stalls for a fixed number
// of wait states, then pulses completion with load data or a misalignment flag.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic [XLEN-1:0] dmem_addr_i,
  input  logic [XLEN-1:0] dmem_wdata_i,
  input  logic [1:0]      dmem_size_i,
  input  logic            dmem_req_i,
  input  logic            wen_i,
  input  logic            dmem_flush_i,
  output logic            dmem_stall_o,
  output logic            dmem_rvalid_o,
  output logic [XLEN-1:0] dmem_rdata_o,
  output logic            dmem_misalign_o
);

  localparam int         AW = $clog2(DEPTH_WORDS);
  localparam int         LA = AW + 2;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [LA-1:0]   addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [1:0]      size_q, size_d;
  logic            wen_q, wen_d;
  logic            mis_q, mis_d;
  logic            do_access;

  logic [LA-1:0]     acc_addr;
  logic [XLEN-1:0]   acc_wdata;
  logic [1:0]        acc_size;
  logic              acc_wen;
  logic              acc_mis;
  logic [XLEN/8-1:0] acc_be;
  logic              sram_en;
  logic [XLEN-1:0]   sram_rdata;
  logic [XLEN-1:0]   load_sh;
  logic [XLEN-1:0]   load_ext;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    wen_d     = wen_q;
    mis_d     = mis_q;
    do_access = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dmem_req_i && !dmem_flush_i) begin
          addr_d  = dmem_addr_i[LA-1:0];
          wdata_d = dmem_wdata_i;
          size_d  = dmem_size_i;
          wen_d   = wen_i;
          mis_d   = is_misaligned(dmem_size_i, dmem_addr_i[1:0]);
          cnt_d   = WS;
          if (WAIT_STATES == 0) begin
            state_d   = ST_DONE;
            do_access = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (dmem_flush_i) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          state_d   = ST_DONE;
          do_access = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With zero wait states the access fires on the accepting edge, so it must use the live request.
  always_comb begin
    acc_addr  = (state_q == ST_IDLE) ? dmem_addr_i[LA-1:0] : addr_q;
    acc_wdata = (state_q == ST_IDLE) ? dmem_wdata_i : wdata_q;
    acc_size  = (state_q == ST_IDLE) ? dmem_size_i : size_q;
    acc_wen   = (state_q == ST_IDLE) ? wen_i : wen_q;
    acc_mis   = is_misaligned(acc_size, acc_addr[1:0]);
    acc_be    = byte_en(acc_size, acc_addr[1:0]);
    sram_en   = do_access && !acc_mis && !reset_i;
  end

  dmem_sram #(
    .DW    (XLEN),
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_sram (
    .clk   (clock_i),
    .en    (sram_en),
    .we    (acc_wen),
    .be    (acc_be),
    .addr  (acc_addr[LA-1:2]),
    .wdata (acc_wdata << {acc_addr[1:0], 3'b000}),
    .rdata (sram_rdata)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      wen_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      wen_q   <= wen_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    load_sh = sram_rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      SIZE_B:  load_ext = {{(XLEN-8){1'b0}}, load_sh[7:0]};
      SIZE_H:  load_ext = {{(XLEN-16){1'b0}}, load_sh[15:0]};
      default: load_ext = load_sh;
    endcase
  end

  assign dmem_stall_o    = !reset_i && (((state_q == ST_IDLE) && dmem_req_i && !dmem_flush_i)
                                        || (state_q == ST_WAIT));
  assign dmem_rvalid_o   = (state_q == ST_DONE);
  assign dmem_misalign_o = (state_q == ST_DONE) && mis_q;
  assign dmem_rdata_o    = ((state_q == ST_DONE) && !mis_q && !wen_q) ? load_ext : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded directed bench: a 2-wait-state responder for function, plus a
// zero-wait-state instance for back-to-back throughput.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, wen, flush;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata;
  logic        stall, rvalid, mis;
  logic        b_req, b_wen, b_flush, b_stall, b_rvalid, b_mis;
  logic [1:0]  b_size;
  logic [31:0] b_addr, b_wdata, b_rdata;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    string       nm;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct packed {
    logic        req;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        rv;
    logic [31:0] rdata;
  } bvec_t;

  localparam bvec_t BV [9] = '{
    '{1'b1, 1'b1, 32'h0, 32'h11111111, 1'b1, 1'b0, 32'h0},
    '{1'b1, 1'b1, 32'h0, 32'h11111111, 1'b0, 1'b1, 32'h0},
    '{1'b1, 1'b1, 32'h4, 32'h22222222, 1'b1, 1'b0, 32'h0},
    '{1'b1, 1'b1, 32'h4, 32'h22222222, 1'b0, 1'b1, 32'h0},
    '{1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 32'h0},
    '{1'b1, 1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 32'h11111111},
    '{1'b1, 1'b0, 32'h4, 32'h0,        1'b1, 1'b0, 32'h0},
    '{1'b1, 1'b0, 32'h4, 32'h0,        1'b0, 1'b1, 32'h22222222},
    '{1'b0, 1'b0, 32'h0, 32'h0,        1'b0, 1'b0, 32'h0}
  };

  always #5 clk = ~clk;

  dmem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(WS)) dut_a (
    .clock_i         (clk),
    .reset_i         (rst),
    .dmem_addr_i     (addr),
    .dmem_wdata_i    (wdata),
    .dmem_size_i     (size),
    .dmem_req_i      (req),
    .wen_i           (wen),
    .dmem_flush_i    (flush),
    .dmem_stall_o    (stall),
    .dmem_rvalid_o   (rvalid),
    .dmem_rdata_o    (rdata),
    .dmem_misalign_o (mis)
  );

  dmem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(0)) dut_b (
    .clock_i         (clk),
    .reset_i         (rst),
    .dmem_addr_i     (b_addr),
    .dmem_wdata_i    (b_wdata),
    .dmem_size_i     (b_size),
    .dmem_req_i      (b_req),
    .wen_i           (b_wen),
    .dmem_flush_i    (b_flush),
    .dmem_stall_o    (b_stall),
    .dmem_rvalid_o   (b_rvalid),
    .dmem_rdata_o    (b_rdata),
    .dmem_misalign_o (b_mis)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, got, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b", nm, got, exp);
    end
  endtask

  // Monitor: every completion pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rvalid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_rvalid: got rvalid=1 with no request outstanding, required 0");
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.nm, " rdata"}, rdata, mon_e.rdata);
        chk1({mon_e.nm, " misalign"}, mis, mon_e.mis);
      end
    end
  end

  task automatic do_access(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                           input logic w, input logic [31:0] er, input logic em, input string nm);
    int c;
    int stall_cnt;
    logic seen;
    sb.push_back('{er, em, nm});
    @(posedge clk); #1;
    req = 1'b1; wen = w; size = sz; addr = a; wdata = d;
    seen = 1'b0;
    stall_cnt = 0;
    for (c = 0; c < 20; c++) begin
      @(negedge clk);
      if (stall) stall_cnt++;
      if (rvalid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s timeout: got no rvalid in 20 cycles, required rvalid in cycle %0d", nm, WS + 1);
    end else begin
      chk({nm, " done_cycle"}, 32'(c), 32'(WS + 1));
      chk({nm, " stall_cycles"}, 32'(stall_cnt), 32'(WS + 1));
    end
    $display("txn %s: size=%0d addr=0x%08h wen=%b rdata=0x%08h misalign=%b done_cycle=%0d",
             nm, sz, a, w, rdata, mis, c);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 1'b1; wen = 1'b0; flush = 1'b0; size = SIZE_W; addr = '0; wdata = '0;
    b_req = 1'b1; b_wen = 1'b0; b_flush = 1'b0; b_size = SIZE_W; b_addr = '0; b_wdata = '0;
    #12;
    chk1("reset stall", stall, 1'b0);
    chk1("reset rvalid", rvalid, 1'b0);
    chk("reset rdata", rdata, 32'h0);
    chk1("reset misalign", mis, 1'b0);
    chk1("reset b_stall", b_stall, 1'b0);
    req = 1'b0; b_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    do_access(SIZE_W, 32'h40, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, "st_w_40");
    do_access(SIZE_W, 32'h40, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, "ld_w_40");

    do_access(SIZE_W, 32'h10, 32'h11223344, 1'b1, 32'h0, 1'b0, "st_w_10");
    do_access(SIZE_B, 32'h13, 32'h0, 1'b0, 32'h00000011, 1'b0, "ld_b_13");
    do_access(SIZE_B, 32'h10, 32'h0, 1'b0, 32'h00000044, 1'b0, "ld_b_10");
    do_access(SIZE_H, 32'h12, 32'h9999ABCD, 1'b1, 32'h0, 1'b0, "st_h_12");
    do_access(SIZE_W, 32'h10, 32'h0, 1'b0, 32'hABCD3344, 1'b0, "ld_w_10a");
    do_access(SIZE_B, 32'h11, 32'hFFFFFF77, 1'b1, 32'h0, 1'b0, "st_b_11");
    do_access(SIZE_W, 32'h10, 32'h0, 1'b0, 32'hABCD7744, 1'b0, "ld_w_10b");
    do_access(SIZE_H, 32'h12, 32'h0, 1'b0, 32'h0000ABCD, 1'b0, "ld_h_12");

    do_access(SIZE_W, 32'h20, 32'hCAFEF00D, 1'b1, 32'h0, 1'b0, "st_w_20");
    do_access(SIZE_H, 32'h21, 32'h00001234, 1'b1, 32'h0, 1'b1, "st_h_21_mis");
    do_access(SIZE_W, 32'h20, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0, "ld_w_20");
    do_access(SIZE_W, 32'h22, 32'h0, 1'b0, 32'h0, 1'b1, "ld_w_22_mis");
    do_access(2'b11, 32'h20, 32'h0, 1'b0, 32'h0, 1'b1, "ld_rsv_20");

    do_access(SIZE_W, 32'h80, 32'h01020304, 1'b1, 32'h0, 1'b0, "st_w_80");
    @(posedge clk); #1;
    req = 1'b1; wen = 1'b1; size = SIZE_W; addr = 32'h80; wdata = 32'hFFFFFFFF;
    @(negedge clk); chk1("flush c0 stall", stall, 1'b1);
    @(posedge clk); #1; flush = 1'b1;
    @(negedge clk); chk1("flush c1 stall", stall, 1'b1);
    @(posedge clk); #1; flush = 1'b0; req = 1'b0;
    @(negedge clk); chk1("flush c2 stall", stall, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk1("flush no_rvalid", rvalid, 1'b0);
    end
    $display("txn flush_st_w_80: aborted in cycle 1");
    do_access(SIZE_W, 32'h80, 32'h0, 1'b0, 32'h01020304, 1'b0, "ld_w_80");

    do_access(SIZE_W, 32'h1000, 32'h5A5A5A5A, 1'b1, 32'h0, 1'b0, "st_w_1000");
    do_access(SIZE_W, 32'h0000, 32'h0, 1'b0, 32'h5A5A5A5A, 1'b0, "ld_w_0_alias");

    do_access(SIZE_W, 32'h44, 32'h13572468, 1'b1, 32'h0, 1'b0, "st_w_44");
    @(posedge clk); #1;
    req = 1'b1; wen = 1'b1; size = SIZE_W; addr = 32'h44; wdata = 32'hFFFF0000;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk1("midreset stall", stall, 1'b0);
    chk1("midreset rvalid", rvalid, 1'b0);
    chk("midreset rdata", rdata, 32'h0);
    chk1("midreset misalign", mis, 1'b0);
    @(posedge clk); #1;
    req = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk1("postreset stall", stall, 1'b0);
    chk1("postreset rvalid", rvalid, 1'b0);
    $display("txn rst_st_w_44: reset during wait");
    do_access(SIZE_W, 32'h44, 32'h0, 1'b0, 32'h13572468, 1'b0, "ld_w_44");

    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      b_req = BV[i].req; b_wen = BV[i].wen; b_addr = BV[i].addr; b_wdata = BV[i].wdata;
      @(negedge clk);
      chk1($sformatf("ws0 row%0d stall", i), b_stall, BV[i].stall);
      chk1($sformatf("ws0 row%0d rvalid", i), b_rvalid, BV[i].rv);
      chk($sformatf("ws0 row%0d rdata", i), b_rdata, BV[i].rdata);
      $display("txn ws0 row%0d: req=%b wen=%b addr=0x%08h stall=%b rvalid=%b rdata=0x%08h",
               i, BV[i].req, BV[i].wen, BV[i].addr, b_stall, b_rvalid, b_rdata);
    end

    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 time units, required earlier finish");
    $fatal(1, "watchdog expired");
  end

endmodule
